// File: rtl/tcp_hdr_classifier.sv
// Buffers the start of each packet, classifies it as IPv4/TCP or not, and
// prepends one tag header word carrying the verdict and the extracted fields.
module tcp_hdr_classifier #(
  parameter int                    DATA_WIDTH     = 64,
  parameter int                    CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] TAG_CTRL       = 8'h40,
  parameter int                    BUF_DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy
);
  localparam int DEPTH = 1 << BUF_DEPTH_BITS;
  localparam int EW    = DATA_WIDTH + CTRL_WIDTH + 1;
  localparam logic [BUF_DEPTH_BITS:0] NEARLY_FULL = (BUF_DEPTH_BITS + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_WAIT = 2'd0, S_TAG = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                  r_state, w_state_nxt;
  logic [EW-1:0]           r_mem [DEPTH];
  logic [BUF_DEPTH_BITS-1:0] r_wr_ptr, r_rd_ptr;
  logic [BUF_DEPTH_BITS:0] r_count;
  logic                    r_eop_held, r_scan_data, r_dec_valid, r_is_tcp, r_ip_ok;
  logic [2:0]              r_wcnt;
  logic [15:0]             r_total_len, r_window;
  logic [3:0]              r_data_off;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [CTRL_WIDTH-1:0]   r_out_ctrl;
  logic                    r_out_wr;

  logic                    w_push, w_pop, w_pop_eop, w_is_data, w_is_eop;
  logic                    w_w2_ok, w_w3_ok, w_dec_set, w_dec_tcp, w_dec_ip_bad;
  logic [2:0]              w_idx;
  logic [EW-1:0]           w_rd_word;
  logic [DATA_WIDTH-1:0]   w_tag, w_out_data;
  logic [CTRL_WIDTH-1:0]   w_out_ctrl;
  logic                    w_out_wr;

  assign in_rdy    = (r_count < NEARLY_FULL) && !r_eop_held;
  assign w_push    = in_wr && in_rdy;
  assign w_pop     = (r_state == S_DRAIN) && out_rdy && (r_count != '0);
  assign w_rd_word = r_mem[r_rd_ptr];
  assign w_pop_eop = w_pop && w_rd_word[EW-1];
  assign w_tag     = {r_is_tcp, r_ip_ok, 14'd0, r_total_len, r_data_off, 12'd0, r_window};
  assign out_data  = r_out_data;
  assign out_ctrl  = r_out_ctrl;
  assign out_wr    = r_out_wr;

  // Word classification and first-decision-wins verdict for the incoming word
  always_comb begin
    w_is_data    = w_push && (r_scan_data || (in_ctrl == '0));
    w_is_eop     = w_is_data && (in_ctrl != '0);
    w_idx        = (r_wcnt == 3'd7) ? 3'd7 : r_wcnt + 3'd1;
    w_w2_ok      = (in_data[31:16] == 16'h0800) && (in_data[15:12] == 4'd4) &&
                   (in_data[11:8] == 4'd5);
    w_w3_ok      = !in_data[29] && (in_data[28:16] == 13'd0) && (in_data[7:0] == 8'h06);
    w_dec_set    = 1'b0;
    w_dec_tcp    = 1'b0;
    w_dec_ip_bad = 1'b0;
    if (!r_dec_valid) begin
      if (w_is_data && (w_idx == 3'd2) && !w_w2_ok) begin
        w_dec_set    = 1'b1;
        w_dec_ip_bad = 1'b1;
      end else if (w_is_data && (w_idx == 3'd3) && !w_w3_ok) begin
        w_dec_set = 1'b1;
      end else if (w_is_data && (w_idx == 3'd7)) begin
        w_dec_set = 1'b1;
        w_dec_tcp = 1'b1;
      end else if (w_is_eop) begin
        w_dec_set = 1'b1;
      end else if (r_count == NEARLY_FULL) begin
        // Buffer full with no verdict: give up on parsing this packet
        w_dec_set    = 1'b1;
        w_dec_ip_bad = 1'b1;
      end else begin
        w_dec_set = 1'b0;
      end
    end else begin
      w_dec_set = 1'b0;
    end
  end

  // Scanner state, field capture and decision register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scan_data <= 1'b0;
      r_wcnt      <= 3'd0;
      r_eop_held  <= 1'b0;
      r_dec_valid <= 1'b0;
      r_is_tcp    <= 1'b0;
      r_ip_ok     <= 1'b0;
      r_total_len <= 16'd0;
      r_data_off  <= 4'd0;
      r_window    <= 16'd0;
    end else if (w_pop_eop) begin
      r_scan_data <= 1'b0;
      r_wcnt      <= 3'd0;
      r_eop_held  <= 1'b0;
      r_dec_valid <= 1'b0;
      r_is_tcp    <= 1'b0;
      r_ip_ok     <= 1'b0;
      r_total_len <= 16'd0;
      r_data_off  <= 4'd0;
      r_window    <= 16'd0;
    end else begin
      if (w_is_data) begin
        r_scan_data <= 1'b1;
        r_wcnt      <= w_idx;
      end
      if (w_is_eop) begin
        r_eop_held <= 1'b1;
      end
      if (!r_dec_valid && w_is_data) begin
        case (w_idx)
          3'd2:    r_ip_ok     <= w_w2_ok;
          3'd3:    r_total_len <= in_data[63:48];
          3'd6:    r_data_off  <= in_data[15:12];
          3'd7:    r_window    <= in_data[63:48];
          default: r_ip_ok     <= r_ip_ok;
        endcase
      end
      if (w_dec_set) begin
        r_dec_valid <= 1'b1;
        r_is_tcp    <= w_dec_tcp;
        if (w_dec_ip_bad) begin
          r_ip_ok <= 1'b0;
        end
      end
    end
  end

  // Buffer storage; the top bit marks the packet's EOP data word
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_is_eop, in_ctrl, in_data};
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_WAIT;
    else        r_state <= w_state_nxt;
  end

  // Output FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:  if (w_dec_set || r_dec_valid) w_state_nxt = S_TAG;   else w_state_nxt = S_WAIT;
      S_TAG:   if (out_rdy)                  w_state_nxt = S_DRAIN; else w_state_nxt = S_TAG;
      S_DRAIN: if (w_pop_eop)                w_state_nxt = S_WAIT;  else w_state_nxt = S_DRAIN;
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Output word selection; data/ctrl hold when nothing is sent
  always_comb begin
    w_out_wr   = 1'b0;
    w_out_data = r_out_data;
    w_out_ctrl = r_out_ctrl;
    case (r_state)
      S_TAG: begin
        if (out_rdy) begin
          w_out_wr   = 1'b1;
          w_out_data = w_tag;
          w_out_ctrl = TAG_CTRL;
        end else begin
          w_out_wr = 1'b0;
        end
      end
      S_DRAIN: begin
        if (w_pop) begin
          w_out_wr   = 1'b1;
          w_out_data = w_rd_word[DATA_WIDTH-1:0];
          w_out_ctrl = w_rd_word[EW-2 -: CTRL_WIDTH];
        end else begin
          w_out_wr = 1'b0;
        end
      end
      default: w_out_wr = 1'b0;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_wr   <= 1'b0;
      r_out_data <= '0;
      r_out_ctrl <= '0;
    end else begin
      r_out_wr   <= w_out_wr;
      r_out_data <= w_out_data;
      r_out_ctrl <= w_out_ctrl;
    end
  end

endmodule
